// File: rtl/echo_fifo_enq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : echo_fifo_enq_arbiter
// Brief    : Round-robin sharing of the echo FIFO enq method among NREQ
//            requesters, each with a one-entry holding slot.
// Revision : 1.0 - initial release
// ============================================================================
module echo_fifo_enq_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_enq__ENA,
    input  logic [NREQ*DATA_WIDTH-1:0] req_enq_v,
    output logic [NREQ-1:0]            req_enq__RDY,
    output logic                       fifo_enq__ENA,
    output logic [DATA_WIDTH-1:0]      fifo_enq_v,
    input  logic                       fifo_enq__RDY,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [31:0]                enq_count
);

    localparam int c_ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       slot_valid_q, slot_valid_d;
    logic [DATA_WIDTH-1:0] slot_data_q [NREQ];
    logic [DATA_WIDTH-1:0] slot_data_d [NREQ];
    logic [c_ID_W-1:0]     last_grant_q, last_grant_d;
    logic [c_ID_W-1:0]     grant_id_q, grant_id_d;
    logic [31:0]           enq_count_q, enq_count_d;

    logic [c_ID_W-1:0]     winner;
    logic [c_ID_W-1:0]     cand;
    logic                  found;

    // Search upward from the slot after the last grant; winner stays 0 when idle.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = c_ID_W'((int'(last_grant_q) + k) % NREQ);
            if (!found && slot_valid_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign req_enq__RDY  = ~slot_valid_q;
    assign fifo_enq__ENA = (|slot_valid_q) && fifo_enq__RDY;
    assign fifo_enq_v    = slot_data_q[winner];
    assign grant_id      = grant_id_q;
    assign enq_count     = enq_count_q;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        enq_count_d  = enq_count_q;

        // A slot being drained is still valid here, so it cannot be refilled this cycle.
        for (int i = 0; i < NREQ; i++) begin
            if (req_enq__ENA[i] && !slot_valid_q[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = req_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (fifo_enq__ENA) begin
            slot_valid_d[winner] = 1'b0;
            last_grant_d         = winner;
            grant_id_d           = winner;
            enq_count_d          = enq_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            slot_valid_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_data_q[i] <= '0;
            end
            last_grant_q <= c_ID_W'(NREQ - 1);
            grant_id_q   <= '0;
            enq_count_q  <= '0;
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            enq_count_q  <= enq_count_d;
        end
    end

endmodule
`default_nettype wire
